// File: rtl/gbuff_dual_port.sv
// Dual-port global buffer. Port A is a two-stage read/write/accumulate pipeline for the
// systolic array; port B is a single-stage byte-enabled port for the PS. A clear engine
// sweeps zeros through every word while busy_o is high.
module gbuff_dual_port #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  output logic                    busy_o,
  input  logic                    a_en_i,
  input  logic                    a_we_i,
  input  logic                    a_acc_i,
  input  logic [ADDR_WIDTH-1:0]   a_addr_i,
  input  logic [DATA_WIDTH-1:0]   a_wdata_i,
  output logic [DATA_WIDTH-1:0]   a_rdata_o,
  output logic                    a_rvalid_o,
  input  logic                    b_en_i,
  input  logic                    b_we_i,
  input  logic [DATA_WIDTH/8-1:0] b_be_i,
  input  logic [ADDR_WIDTH-1:0]   b_addr_i,
  input  logic [DATA_WIDTH-1:0]   b_wdata_i,
  output logic [DATA_WIDTH-1:0]   b_rdata_o,
  output logic                    b_rvalid_o
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam logic [0:0]  StIdle   = 1'b0;
  localparam logic [0:0]  StClr    = 1'b1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  // Stage-2 (commit) registers of port A
  logic                  s2_valid_q, s2_valid_d;
  logic                  s2_we_q, s2_we_d;
  logic                  s2_acc_q, s2_acc_d;
  logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
  logic [DATA_WIDTH-1:0] s2_wdata_q, s2_wdata_d;
  logic [DATA_WIDTH-1:0] s2_rdata_q, s2_rdata_d;

  logic                  a_res_valid_q, a_res_valid_d;
  logic [DATA_WIDTH-1:0] a_res_q, a_res_d;
  logic                  b_res_valid_q, b_res_valid_d;
  logic [DATA_WIDTH-1:0] b_res_q, b_res_d;

  logic                  accept, a_req, b_req, s2_wr, b_wr, clr_wr;
  logic [DATA_WIDTH-1:0] s2_result, a_rd, b_old, b_merged;

  // Clear FSM: one zero write per cycle from address 0 up to DEPTH-1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_wr  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clr_i) begin
          state_d = StClr;
          cnt_d   = '0;
        end
      end
      StClr: begin
        clr_wr = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Port A: stage 1 reads (with forwarding from stage 2), stage 2 computes and commits
  always_comb begin
    // A clear request takes priority over new traffic arriving in the same cycle
    accept    = (state_q == StIdle) && !clr_i;
    a_req     = a_en_i && accept;
    s2_wr     = s2_valid_q && s2_we_q;
    s2_result = s2_rdata_q;
    if (s2_we_q) s2_result = s2_acc_q ? (s2_rdata_q + s2_wdata_q) : s2_wdata_q;
    a_rd = (s2_wr && (s2_addr_q == a_addr_i)) ? s2_result : mem_q[a_addr_i];

    s2_valid_d    = a_req;
    s2_we_d       = a_we_i;
    s2_acc_d      = a_acc_i;
    s2_addr_d     = a_addr_i;
    s2_wdata_d    = a_wdata_i;
    s2_rdata_d    = a_rd;
    a_res_valid_d = s2_valid_q;
    a_res_d       = s2_valid_q ? s2_result : a_res_q;
  end

  // Port B: byte merge; a write colliding with a port-A commit is dropped
  always_comb begin
    b_req    = b_en_i && accept;
    b_old    = mem_q[b_addr_i];
    b_merged = b_old;
    for (int unsigned k = 0; k < NumBytes; k++) begin
      if (b_be_i[k]) b_merged[8*k +: 8] = b_wdata_i[8*k +: 8];
    end
    b_wr          = b_req && b_we_i && (|b_be_i) && !(s2_wr && (s2_addr_q == b_addr_i));
    b_res_valid_d = b_req;
    b_res_d       = b_req ? (b_wr ? b_merged : b_old) : b_res_q;
  end

  // Control and pipeline state; reset flushes stage 2 so a pending write is lost
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      s2_valid_q    <= 1'b0;
      s2_we_q       <= 1'b0;
      s2_acc_q      <= 1'b0;
      s2_addr_q     <= '0;
      s2_wdata_q    <= '0;
      s2_rdata_q    <= '0;
      a_res_valid_q <= 1'b0;
      a_res_q       <= '0;
      b_res_valid_q <= 1'b0;
      b_res_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      s2_valid_q    <= s2_valid_d;
      s2_we_q       <= s2_we_d;
      s2_acc_q      <= s2_acc_d;
      s2_addr_q     <= s2_addr_d;
      s2_wdata_q    <= s2_wdata_d;
      s2_rdata_q    <= s2_rdata_d;
      a_res_valid_q <= a_res_valid_d;
      a_res_q       <= a_res_d;
      b_res_valid_q <= b_res_valid_d;
      b_res_q       <= b_res_d;
    end
  end

  // Array writes; later statements win, so A beats B and the sweep beats both
  always_ff @(posedge clk_i) begin
    if (b_wr)   mem_q[b_addr_i]  <= b_merged;
    if (s2_wr)  mem_q[s2_addr_q] <= s2_result;
    if (clr_wr) mem_q[cnt_q]     <= '0;
  end

  assign busy_o = (state_q == StClr);

  if (OUT_REG != 0) begin : g_out_reg
    logic                  a_out_valid_q, b_out_valid_q;
    logic [DATA_WIDTH-1:0] a_out_q, b_out_q;

    // Extra output stage; data only moves with a valid result so it holds otherwise
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        a_out_valid_q <= 1'b0;
        b_out_valid_q <= 1'b0;
        a_out_q       <= '0;
        b_out_q       <= '0;
      end else begin
        a_out_valid_q <= a_res_valid_q;
        b_out_valid_q <= b_res_valid_q;
        if (a_res_valid_q) a_out_q <= a_res_q;
        if (b_res_valid_q) b_out_q <= b_res_q;
      end
    end

    assign a_rvalid_o = a_out_valid_q;
    assign a_rdata_o  = a_out_q;
    assign b_rvalid_o = b_out_valid_q;
    assign b_rdata_o  = b_out_q;
  end else begin : g_no_out_reg
    assign a_rvalid_o = a_res_valid_q;
    assign a_rdata_o  = a_res_q;
    assign b_rvalid_o = b_res_valid_q;
    assign b_rdata_o  = b_res_q;
  end

endmodule

// File: tb/tb_gbuff_dual_port.sv
// Bench for gbuff_dual_port: two instances (OUT_REG=0 and OUT_REG=1) share one stimulus
// stream. A transaction-level memory model produces the expected result and due cycle of
// every request; a negedge monitor pops and compares whenever a DUT raises rvalid.
module tb_gbuff_dual_port;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NB = 4;
  localparam int DEPTH = 256;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          clr_i = 1'b0;
  logic          a_en = 1'b0, a_we = 1'b0, a_acc = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          b_en = 1'b0, b_we = 1'b0;
  logic [NB-1:0] b_be = '0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;

  logic          busy0, busy1, a_rv0, a_rv1, b_rv0, b_rv1;
  logic [DW-1:0] a_rd0, a_rd1, b_rd0, b_rd1;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;

  exp_t qa0[$], qa1[$], qb0[$], qb1[$];
  logic [DW-1:0] last_a0 = '0, last_a1 = '0, last_b0 = '0, last_b1 = '0;

  // Reference model: committed memory plus the port-A write due to land this cycle
  logic [DW-1:0] model [DEPTH];
  bit            pend_v = 1'b0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] pend_val = '0;

  gbuff_dual_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .OUT_REG(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy0),
    .a_en_i(a_en), .a_we_i(a_we), .a_acc_i(a_acc), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rdata_o(a_rd0), .a_rvalid_o(a_rv0),
    .b_en_i(b_en), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rdata_o(b_rd0), .b_rvalid_o(b_rv0)
  );

  gbuff_dual_port #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .OUT_REG(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .busy_o(busy1),
    .a_en_i(a_en), .a_we_i(a_we), .a_acc_i(a_acc), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_rdata_o(a_rd1), .a_rvalid_o(a_rv1),
    .b_en_i(b_en), .b_we_i(b_we), .b_be_i(b_be), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_rdata_o(b_rd1), .b_rvalid_o(b_rv1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic sb_cmp(input string name, input logic [DW-1:0] got, input exp_t e);
    n_vec++;
    if (got !== e.data || cyc != e.due) begin
      n_fail++;
      $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
               name, got, cyc, e.data, e.due);
    end
  endtask

  task automatic sb_err(input string name, input string what);
    n_vec++;
    n_fail++;
    $display("FAIL %s: %s at cycle %0d", name, what, cyc);
  endtask

  // Monitor: pop on every rvalid, flag late/unexpected results, check hold when idle
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_i) begin
      if (a_rv0) begin
        if (qa0.size() == 0) sb_err("a0", "unexpected rvalid");
        else begin e = qa0.pop_front(); sb_cmp("a0", a_rd0, e); last_a0 = e.data; end
      end else begin
        if (qa0.size() != 0 && qa0[0].due < cyc) begin sb_err("a0", "missing rvalid"); void'(qa0.pop_front()); end
        chk("a0_hold", a_rd0, last_a0);
      end
      if (a_rv1) begin
        if (qa1.size() == 0) sb_err("a1", "unexpected rvalid");
        else begin e = qa1.pop_front(); sb_cmp("a1", a_rd1, e); last_a1 = e.data; end
      end else begin
        if (qa1.size() != 0 && qa1[0].due < cyc) begin sb_err("a1", "missing rvalid"); void'(qa1.pop_front()); end
        chk("a1_hold", a_rd1, last_a1);
      end
      if (b_rv0) begin
        if (qb0.size() == 0) sb_err("b0", "unexpected rvalid");
        else begin e = qb0.pop_front(); sb_cmp("b0", b_rd0, e); last_b0 = e.data; end
      end else begin
        if (qb0.size() != 0 && qb0[0].due < cyc) begin sb_err("b0", "missing rvalid"); void'(qb0.pop_front()); end
        chk("b0_hold", b_rd0, last_b0);
      end
      if (b_rv1) begin
        if (qb1.size() == 0) sb_err("b1", "unexpected rvalid");
        else begin e = qb1.pop_front(); sb_cmp("b1", b_rd1, e); last_b1 = e.data; end
      end else begin
        if (qb1.size() != 0 && qb1[0].due < cyc) begin sb_err("b1", "missing rvalid"); void'(qb1.pop_front()); end
        chk("b1_hold", b_rd1, last_b1);
      end
    end
  end

  // One cycle of traffic on both ports; expectations come from the memory model
  task automatic step(input bit ae, input bit awe, input bit aacc, input logic [AW-1:0] aad,
                      input logic [DW-1:0] awd, input bit ben, input bit bwe,
                      input logic [NB-1:0] bbe, input logic [AW-1:0] bad,
                      input logic [DW-1:0] bwd);
    exp_t          e;
    logic [DW-1:0] seen, res, old, merged;
    bit            nv;
    logic [AW-1:0] naddr;
    logic [DW-1:0] nval;
    a_en = ae; a_we = awe; a_acc = aacc; a_addr = aad; a_wdata = awd;
    b_en = ben; b_we = bwe; b_be = bbe; b_addr = bad; b_wdata = bwd;
    nv = 1'b0; naddr = '0; nval = '0;
    if (ae) begin
      // Port A sees its own earlier writes in program order
      seen = (pend_v && pend_addr == aad) ? pend_val : model[aad];
      res  = !awe ? seen : (aacc ? seen + awd : awd);
      e.data = res; e.due = cyc + 2; qa0.push_back(e);
      e.due = cyc + 3; qa1.push_back(e);
      nv = awe; naddr = aad; nval = res;
    end
    if (ben) begin
      old = model[bad];
      merged = old;
      for (int k = 0; k < NB; k++) if (bbe[k]) merged[8*k +: 8] = bwd[8*k +: 8];
      if (bwe && bbe != '0 && !(pend_v && pend_addr == bad)) begin
        model[bad] = merged;
        e.data = merged;
      end else begin
        e.data = old;
      end
      e.due = cyc + 1; qb0.push_back(e);
      e.due = cyc + 2; qb1.push_back(e);
    end
    if (pend_v) model[pend_addr] = pend_val;
    pend_v = nv; pend_addr = naddr; pend_val = nval;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, 0, 0, '0, '0, '0);
  endtask

  task automatic a_op(input bit we, input bit acc, input logic [AW-1:0] ad,
                      input logic [DW-1:0] wd);
    step(1, we, acc, ad, wd, 0, 0, '0, '0, '0);
  endtask

  task automatic b_op(input bit we, input logic [NB-1:0] be, input logic [AW-1:0] ad,
                      input logic [DW-1:0] wd);
    step(0, 0, 0, '0, '0, 1, we, be, ad, wd);
  endtask

  task automatic do_clear();
    a_en = 0; b_en = 0; clr_i = 1'b1;
    if (pend_v) model[pend_addr] = pend_val;
    pend_v = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    @(posedge clk); #1;
    clr_i = 1'b0;
  endtask

  initial begin : main
    int nb0, nb1;
    bit r_ae, r_awe, r_aacc, r_ben, r_bwe;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy0", {31'b0, busy0}, 0);
    chk("rst_busy1", {31'b0, busy1}, 0);
    chk("rst_arv0", {31'b0, a_rv0}, 0);
    chk("rst_brv1", {31'b0, b_rv1}, 0);
    chk("rst_ard0", a_rd0, 0);
    chk("rst_brd1", b_rd1, 0);
    rst_i = 1'b0;

    // Memory is not reset: give every word a known value before relying on the model
    do_clear();
    for (int i = 0; i < 400 && (busy0 || busy1); i++) begin @(posedge clk); #1; end

    // Write via A, read via B (first while A is still committing, then after)
    a_op(1, 0, 8'd5, 32'h1234_5678);
    b_op(0, '0, 8'd5, '0);
    b_op(0, '0, 8'd5, '0);
    // Byte-enabled B write
    b_op(1, 4'hF, 8'd20, 32'h1111_1111);
    b_op(1, 4'b0101, 8'd20, 32'hAABB_CCDD);
    b_op(0, '0, 8'd20, '0);
    a_op(0, 0, 8'd20, '0);
    b_op(1, 4'h0, 8'd20, 32'hFFFF_FFFF);
    // Back-to-back accumulates through the forwarding path, then wrap
    a_op(1, 0, 8'd7, 32'd10);
    repeat (4) a_op(1, 1, 8'd7, 32'd3);
    a_op(0, 0, 8'd7, '0);
    a_op(1, 0, 8'd8, 32'hFFFF_FFFF);
    a_op(1, 1, 8'd8, 32'd1);
    a_op(0, 0, 8'd8, '0);
    // A commit collides with B write: A wins, B returns the old word
    b_op(1, 4'hF, 8'd9, 32'h55);
    idle();
    a_op(1, 0, 8'd9, 32'h1);
    b_op(1, 4'hF, 8'd9, 32'h2);
    idle();
    a_op(0, 0, 8'd9, '0);
    b_op(0, '0, 8'd9, '0);
    // Same-cycle A read while B writes: read-first across ports
    step(1, 0, 0, 8'd12, '0, 1, 1, 4'hF, 8'd12, 32'h77);
    a_op(0, 0, 8'd12, '0);

    // Random traffic on a narrow window to provoke forwarding and collisions
    for (int i = 0; i < 300; i++) begin
      r_ae   = ($urandom_range(0, 3) != 0);
      r_awe  = 1'($urandom_range(0, 1));
      r_aacc = r_awe & 1'($urandom_range(0, 1));
      r_ben  = ($urandom_range(0, 3) != 0);
      r_bwe  = 1'($urandom_range(0, 1));
      step(r_ae, r_awe, r_aacc, AW'($urandom_range(0, 15)), $urandom,
           r_ben, r_bwe, NB'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), $urandom);
    end
    a_op(1, 1, 8'd3, 32'd1);

    // Clear sweep with an A op still in flight; requests during the sweep are ignored
    do_clear();
    nb0 = 0; nb1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy0 && !busy1) break;
      if (busy0) nb0++;
      if (busy1) nb1++;
      a_en = 1; a_we = 1'($urandom_range(0, 1)); a_acc = 0;
      a_addr = AW'($urandom); a_wdata = $urandom | 32'h1;
      b_en = 1; b_we = 1; b_be = '1; b_addr = AW'($urandom); b_wdata = $urandom | 32'h1;
      @(posedge clk); #1;
    end
    a_en = 0; b_en = 0;
    chk("busy_len0", nb0, DEPTH);
    chk("busy_len1", nb1, DEPTH);
    for (int i = 0; i < DEPTH; i++)
      step(1, 0, 0, AW'(i), '0, 1, 0, '0, AW'(DEPTH - 1 - i), '0);
    repeat (5) idle();
    chk("drain_a0", qa0.size(), 0);
    chk("drain_a1", qa1.size(), 0);
    chk("drain_b0", qb0.size(), 0);
    chk("drain_b1", qb1.size(), 0);

    // Reset mid-sweep: outputs drop immediately
    a_op(1, 0, 8'd3, 32'hCAFE_F00D);
    b_op(1, 4'hF, 8'd4, 32'h0BAD_BEEF);
    repeat (4) idle();
    do_clear();
    repeat (99) begin @(posedge clk); #1; end
    chk("mid_busy0", {31'b0, busy0}, 1);
    rst_i = 1'b1;
    qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete();
    last_a0 = '0; last_a1 = '0; last_b0 = '0; last_b1 = '0;
    pend_v = 1'b0;
    #1;
    chk("rst2_busy0", {31'b0, busy0}, 0);
    chk("rst2_busy1", {31'b0, busy1}, 0);
    chk("rst2_ard0", a_rd0, 0);
    chk("rst2_ard1", a_rd1, 0);
    chk("rst2_brd0", b_rd0, 0);
    chk("rst2_brd1", b_rd1, 0);
    chk("rst2_arv1", {31'b0, a_rv1}, 0);
    chk("rst2_brv0", {31'b0, b_rv0}, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/gbuff_dual_port.md
# gbuff_dual_port

Parametrised dual-port global buffer that succeeds the single-port input/weight/output buffer. Port A serves the systolic array with read, write and in-place accumulate. Port B serves the PS with byte-enabled read/write. A built-in clear engine zeroes the whole array without PS involvement.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- DEPTH, 256: number of words.
- ADDR_WIDTH, 8: address width; DEPTH <= 2^ADDR_WIDTH.
- OUT_REG, 0: 1 adds one output register stage to both ports.

Ports:
- clk_i  in  1  clock; everything is on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- clr_i  in  1  one-cycle pulse that starts a clear sweep.
- busy_o  out  1  high while a clear sweep is running.
- a_en_i  in  1  port A request.
- a_we_i  in  1  port A write.
- a_acc_i  in  1  port A accumulate; only valid together with a_we_i.
- a_addr_i  in  ADDR_WIDTH  port A address.
- a_wdata_i  in  DATA_WIDTH  port A write data or addend.
- a_rdata_o  out  DATA_WIDTH  port A result.
- a_rvalid_o  out  1  a_rdata_o is valid.
- b_en_i  in  1  port B request.
- b_we_i  in  1  port B write.
- b_be_i  in  DATA_WIDTH/8  port B byte enables; bit k covers bits [8k+7:8k].
- b_addr_i  in  ADDR_WIDTH  port B address.
- b_wdata_i  in  DATA_WIDTH  port B write data.
- b_rdata_o  out  DATA_WIDTH  port B result.
- b_rvalid_o  out  1  b_rdata_o is valid.

## Operation
- Port A is a 2-stage pipeline and accepts one request per cycle.
  - Stage 1 reads mem[addr].
  - Stage 2 commits any write and produces the result.
- Port A op decode:
  - en & !we: read. Result = mem[addr].
  - en & we & !acc: write. mem[addr] <= wdata. Result = wdata (write-first).
  - en & we & acc: accumulate. mem[addr] <= mem[addr] + wdata. Result = the sum.
- Accumulate sum wraps modulo 2^DATA_WIDTH; there is no saturation.
- Port A forwarding: if a stage-1 op hits the same address as the stage-2 write in the same cycle, stage 1 uses the stage-2 result, not the stale array value. Back-to-back accumulates to one address therefore add exactly.
- Port B is single-stage.
  - Write: bytes with b_be_i set are taken from wdata; the rest keep the old value.
  - Result = merged word (write-first).
  - Read: result = mem[addr].
  - b_we_i with b_be_i = 0 acts as a read.
- Cross-port collisions:
  - Port A stage-2 write and port B write to the same address in the same cycle: A commits, B's write is dropped, b_rdata_o returns the pre-cycle word.
  - A port reading an address the other port writes in the same cycle gets the old value (read-first across ports).
- Clear FSM has two states, IDLE and CLR.
  - IDLE -> CLR on clr_i. Address counter loads 0 and busy_o goes to 1.
  - In CLR, the FSM writes 0 to counter address each cycle and increments the counter.
  - CLR -> IDLE after writing address DEPTH-1. busy_o drops on the next cycle.
  - While in CLR, a_en_i and b_en_i are ignored (no rvalid) and clr_i is ignored.
  - Port A ops already in stage 2 when clr_i is taken still complete. The sweep starts after them.
- Reset:
  - All outputs go to 0 and the FSM goes to IDLE.
  - The pipeline is flushed; a pending stage-2 write is discarded.
  - Memory contents are not reset.
  - Reset mid-sweep leaves memory partially cleared, contents unspecified.

## Timing
- Port A latency is 2+OUT_REG cycles from an accepted request to a_rvalid_o, for all op types.
- Port B latency is 1+OUT_REG cycles.
- rvalid outputs are single-cycle and in request order. Fully pipelined, one result per cycle sustained.
- a_rdata_o and b_rdata_o hold their last value when rvalid is low.
- A clear takes exactly DEPTH cycles of busy_o=1. The first new request is accepted on the first cycle after busy_o drops.
- Memory writes commit at the clock edge ending the commit stage, so a same-port read issued the next cycle sees the new value.

## Test plan
- Reset, then write 0x1234_5678 to A@5, then read B@5: b_rvalid_o at latency 1, b_rdata_o = 0x1234_5678; a_rdata_o/b_rdata_o = 0 before the first access.
- B write 0xAABB_CCDD with be=4'b0101 to a word holding 0x1111_1111: result and later read = 0x11BB_11DD.
- Four consecutive A accumulates of 3 to @7 holding 10: results 13, 16, 19, 22; final mem = 22 (exercises forwarding). Accumulate 1 to 0xFFFF_FFFF: result 0.
- Same-cycle commit: A write 0x1 and B write 0x2 to @9: mem = 0x1, b_rdata_o = old value.
- clr_i with DEPTH=256: busy_o high for 256 cycles, requests ignored during the sweep, all reads afterwards return 0. Assert rst_i at cycle 100: busy_o = 0 immediately, outputs 0.
- Repeat the accumulate and read tests with OUT_REG=1: latencies become 3 (A) and 2 (B), same data.
